// File: rtl/dcache_victim_buffer_pkg.sv
// Shared types for the dcache victim buffer: bus words, the write-unit request
// payload and line-offset geometry.
package dcache_victim_buffer_pkg;

  localparam int unsigned LINE_WORD_NUM = 8;
  localparam int unsigned OFFSET_W      = $clog2(LINE_WORD_NUM) + 2;
  localparam int unsigned LINE_BYTES    = LINE_WORD_NUM * 4;
  localparam logic [2:0]  SIZE_WORD     = 3'b010;

  typedef logic [31:0] word;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  wen;
  } mem_write_req;

  // Clears the byte offset within a cache line.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/victim_addr_cam.sv
// Fully associative line-address match over the valid victim slots.
module victim_addr_cam #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]  valid,
  input  logic [31:0]   line_addr [N],
  input  logic [31:0]   lookup_line,
  output logic          hit
);

  logic [N-1:0] match;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < N; i++) begin
      match[i] = valid[i] && (line_addr[i] == lookup_line);
    end
  end

  assign hit = |match;

endmodule

// File: rtl/dcache_victim_buffer.sv
// Holds dirty dcache victims until the memory write unit retires them; slot
// index follows the write unit's lock/key so both sides stay in step.
module dcache_victim_buffer
  import dcache_victim_buffer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_evict_valid,
  output logic                                  o_evict_ready,
  input  logic [31:0]                           i_evict_addr,
  input  word  [LINE_WORD_NUM-1:0]              i_evict_data,
  input  logic [$clog2(FIFO_DEPTH)-2:0]         i_lock,
  output logic                                  o_dcache_we,
  output mem_write_req                          o_dcache_req,
  input  logic [$clog2(FIFO_DEPTH)-1:0]         i_key,
  output word  [LINE_WORD_NUM-1:0]              o_line_data,
  input  logic                                  i_dcache_end,
  input  logic [31:0]                           i_lookup_addr,
  output logic                                  o_lookup_hit,
  output logic                                  o_empty
);

  localparam int unsigned BUFFER_NUM = FIFO_DEPTH / 2;
  localparam int unsigned KEY_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned LOCK_W     = KEY_W - 1;

  typedef struct packed {
    logic [31:0]              line_addr;
    word [LINE_WORD_NUM-1:0]  data;
  } victim_slot_t;

  victim_slot_t            slots [BUFFER_NUM];
  logic [BUFFER_NUM-1:0]   r_valid;
  logic                    accept;
  logic [31:0]             evict_line;
  logic [LOCK_W-1:0]       key_slot;
  logic                    key_sram;
  logic [31:0]             slot_line [BUFFER_NUM];

  assign key_slot   = i_key[LOCK_W-1:0];
  assign key_sram   = i_key[KEY_W-1];
  assign evict_line = line_align(i_evict_addr);

  // Readiness comes from registered state only; a slot freeing this cycle is not reused.
  assign o_evict_ready = ~&r_valid;
  assign accept        = i_evict_valid && o_evict_ready && !i_rst;
  assign o_dcache_we   = accept;
  assign o_empty       = ~|r_valid;

  always_comb begin
    o_dcache_req = '0;
    if (accept) begin
      o_dcache_req.addr = evict_line;
      o_dcache_req.len  = 8'(LINE_WORD_NUM - 1);
      o_dcache_req.size = SIZE_WORD;
      o_dcache_req.wen  = 4'hf;
    end
  end

  // Valid bits: free on write-unit completion, set on accept; targets never collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      if (i_dcache_end && !key_sram) r_valid[key_slot] <= 1'b0;
      if (accept)                    r_valid[i_lock]   <= 1'b1;
    end
  end

  // Slot payload is intentionally not reset; r_valid alone qualifies it.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      slots[i_lock].line_addr <= evict_line;
      slots[i_lock].data      <= i_evict_data;
    end
  end

  assign o_line_data = slots[key_slot].data;

  always_comb begin
    for (int unsigned i = 0; i < BUFFER_NUM; i++) begin
      slot_line[i] = slots[i].line_addr;
    end
  end

  victim_addr_cam #(
    .N (BUFFER_NUM)
  ) u_cam (
    .valid       (r_valid),
    .line_addr   (slot_line),
    .lookup_line (line_align(i_lookup_addr)),
    .hit         (o_lookup_hit)
  );

  a_accept_free_slot : assert property (
    @(posedge i_clk) disable iff (i_rst) accept |-> !r_valid[i_lock]
  );

endmodule
